execution_controller: RTL and testbench

- Sequences execution of the pipelined processor for the debug unit.
- Drives the global enable consumed by program_counter and the pipeline registers.
- Runs the program in continuous or single-step mode on host commands, detects program end (HALT), drains in-flight instructions, then freezes the machine.
- Reports cycle count and final PC.

---
 rtl/execution_controller.sv | 157 +++++++++++++++
 tb/tb_execution_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_controller.sv
// execution_controller: sequences the pipelined processor for the debug unit.
// It runs the program continuously or one step at a time on host commands.
// On HALT it drains the in-flight instructions, then freezes the machine.
// It reports the number of enabled cycles and the PC captured at the end.
// Optional breakpoint support is enabled by defining EXEC_BREAKPOINT_EN.
module execution_controller #(
  parameter int PC_SIZE      = 32,
  parameter int CNT_SIZE     = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt,
  input  logic [PC_SIZE-1:0]  i_pc,
`ifdef EXEC_BREAKPOINT_EN
  input  logic                i_bp_valid,
  input  logic [PC_SIZE-1:0]  i_bp_addr,
`endif
  output logic                o_pipeline_enable,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_SIZE-1:0] o_cycle_count,
  output logic [PC_SIZE-1:0]  o_last_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t     state;
  state_t     next;
  cmd_t       cmd_in;
  logic       accept;
  logic       bp_hit;
  logic       clr_cnt;
  logic       clr_pc;
  logic [3:0] drain_cnt;

  assign cmd_in = cmd_t'(i_cmd);
  assign accept = i_cmd_valid && o_cmd_ready;

`ifdef EXEC_BREAKPOINT_EN
  assign bp_hit = i_bp_valid && (i_pc == i_bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  // Handshake and busy flags decoded directly from the current state
  always_comb begin
    o_cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_DONE);
    o_busy      = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
  end

  // Next-state selection; HALT outranks breakpoint and STOP while running
  always_comb begin
    next    = state;
    clr_cnt = 1'b0;
    clr_pc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_in)
            CMD_RUN:   next = S_RUN;
            CMD_STEP:  next = S_STEP;
            CMD_CLEAR: clr_cnt = 1'b1;
            default:   next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt)                               next = S_DRAIN;
        else if (bp_hit)                          next = S_IDLE;
        else if (accept && (cmd_in == CMD_STOP))  next = S_IDLE;
      end
      S_STEP: begin
        next = i_halt ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (drain_cnt <= 4'd1) next = S_DONE;
      end
      S_DONE: begin
        if (accept && (cmd_in == CMD_CLEAR)) begin
          clr_cnt = 1'b1;
          clr_pc  = 1'b1;
          next    = S_IDLE;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // State register; enable is registered from the next state so it is high
  // exactly in the cycles spent in RUN, STEP and DRAIN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= S_IDLE;
      o_pipeline_enable <= 1'b0;
    end else begin
      state             <= next;
      o_pipeline_enable <= (next == S_RUN) || (next == S_STEP) || (next == S_DRAIN);
    end
  end

  // Drain down-counter, loaded on entry to DRAIN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drain_cnt <= '0;
    end else if ((state != S_DRAIN) && (next == S_DRAIN)) begin
      drain_cnt <= DRAIN_INIT;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt - 4'd1;
    end
  end

  // Saturating count of enabled cycles
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cycle_count <= '0;
    end else if (clr_cnt) begin
      o_cycle_count <= '0;
    end else if (o_pipeline_enable && (o_cycle_count != '1)) begin
      o_cycle_count <= o_cycle_count + CNT_SIZE'(1);
    end
  end

  // Done pulse and final PC capture on the DRAIN-to-DONE transition
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_done    <= 1'b0;
      o_last_pc <= '0;
    end else begin
      o_done <= (state == S_DRAIN) && (next == S_DONE);
      if (clr_pc) begin
        o_last_pc <= '0;
      end else if ((state == S_DRAIN) && (next == S_DONE)) begin
        o_last_pc <= i_pc;
      end
    end
  end

endmodule

// File: tb/tb_execution_controller.sv
// Scoreboard bench for execution_controller. Stimulus tasks compute each
// transaction's expected burst length, counter and final PC arithmetically;
// a negedge monitor compares whenever an enable burst ends or o_done fires.
module tb_execution_controller;
  localparam int PCW  = 32;
  localparam int CW   = 5;
  localparam int D    = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [1:0] C_CLEAR = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_STOP = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [1:0]     cmd = 2'b00;
  logic           halt = 1'b0;
  logic [PCW-1:0] pc;
  logic           cmd_ready, en, busy, done;
  logic [CW-1:0]  count;
  logic [PCW-1:0] last_pc;
`ifdef EXEC_BREAKPOINT_EN
  logic           bp_valid = 1'b0;
  logic [PCW-1:0] bp_addr = '0;
`endif

  always #5 clk = ~clk;

  execution_controller #(.PC_SIZE(PCW), .CNT_SIZE(CW), .DRAIN_CYCLES(D)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(cmd_ready), .i_halt(halt), .i_pc(pc),
`ifdef EXEC_BREAKPOINT_EN
    .i_bp_valid(bp_valid), .i_bp_addr(bp_addr),
`endif
    .o_pipeline_enable(en), .o_busy(busy), .o_done(done),
    .o_cycle_count(count), .o_last_pc(last_pc)
  );

  // Program counter stand-in: advances by 4 on every enabled cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (en) pc <= pc + 32'd4;
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference model state
  int     m_count = 0;
  longint m_pc = 0;
  longint m_last = 0;

  typedef struct { int len; int cnt; } burst_t;
  typedef struct { int cnt; longint last; } done_t;
  burst_t bq[$];
  done_t  dq[$];

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic void expect_burst(input int len, input bit with_done);
    m_count = sat(m_count + len);
    bq.push_back('{len, m_count});
    if (with_done) begin
      m_last = m_pc + 4 * (len - 1);
      dq.push_back('{m_count, m_last});
    end
    m_pc = m_pc + 4 * len;
  endfunction

  // Monitor: pops the scoreboard when a burst ends or o_done fires
  int  run_len = 0;
  bit  prev_en = 1'b0;
  always @(negedge clk) begin
    burst_t b;
    done_t  d;
    if (!rst_n) begin
      run_len = 0;
      prev_en = 1'b0;
    end else begin
      chk("busy_vs_enable", busy, en);
      if (en) begin
        run_len++;
      end else if (prev_en) begin
        chk("burst_queued", bq.size() > 0, 1);
        if (bq.size() > 0) begin
          b = bq.pop_front();
          chk("burst_len", run_len, b.len);
          chk("burst_count", count, b.cnt);
        end
        run_len = 0;
      end
      if (done) begin
        chk("done_queued", dq.size() > 0, 1);
        if (dq.size() > 0) begin
          d = dq.pop_front();
          chk("done_count", count, d.cnt);
          chk("done_last_pc", last_pc, d.last);
          chk("done_enable", en, 0);
        end
      end
      prev_en = en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    for (int t = 0; t < 50 && !cmd_ready; t++) tick();
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #2;
    chk("reset_enable", en, 0);
    chk("reset_count", count, 0);
    chk("reset_last_pc", last_pc, 0);
    chk("reset_done", done, 0);
    tick();
    rst_n = 1'b1;
    m_count = 0; m_pc = 0; m_last = 0;
    chk("reset_ready", cmd_ready, 1);
  endtask

  task automatic run_halt(input int n, input bit with_stop);
    expect_burst(n + D, 1'b1);
    issue(C_RUN);
    for (int i = 1; i < n; i++) tick();
    halt = 1'b1;
    if (with_stop) begin cmd_valid = 1'b1; cmd = C_STOP; end
    tick();
    halt = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < D; i++) tick();
  endtask

  task automatic step(input bit with_halt);
    expect_burst(with_halt ? 1 + D : 1, with_halt);
    issue(C_STEP);
    if (with_halt) begin
      halt = 1'b1;
      tick();
      halt = 1'b0;
      for (int i = 0; i < D; i++) tick();
    end
  endtask

  task automatic run_stop(input int k, input bit noise);
    expect_burst(k, 1'b0);
    issue(C_RUN);
    for (int i = 1; i < k; i++) begin
      if (noise && $urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b1;
        cmd = 2'($urandom_range(0, 2));
      end
      tick();
      cmd_valid = 1'b0;
    end
    issue(C_STOP);
  endtask

  task automatic done_cmds(input int n);
    for (int i = 0; i < n; i++) issue(2'($urandom_range(1, 3)));
    chk("done_hold_enable", en, 0);
    chk("done_hold_busy", busy, 0);
    chk("done_hold_count", count, m_count);
    chk("done_hold_last_pc", last_pc, m_last);
    issue(C_CLEAR);
    m_count = 0;
    m_last = 0;
    chk("clear_count", count, 0);
    chk("clear_last_pc", last_pc, 0);
    chk("clear_ready", cmd_ready, 1);
    chk("clear_enable", en, 0);
  endtask

  task automatic run_halt_reset(input int n);
    issue(C_RUN);
    for (int i = 1; i < n; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    chk("mid_drain_enable", en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_enable", en, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_last_pc", last_pc, 0);
    m_count = 0; m_pc = 0; m_last = 0;
    tick();
    rst_n = 1'b1;
    chk("post_rst_ready", cmd_ready, 1);
    tick();
    chk("post_rst_enable", en, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("init_enable", en, 0);
    chk("init_count", count, 0);
    chk("init_last_pc", last_pc, 0);
    chk("init_done", done, 0);
    chk("init_ready", cmd_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_halt(10, 1'b0);
    issue(C_RUN);
    done_cmds(0);

    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      repeat ($urandom_range(1, 3)) tick();
    end
    issue(C_STOP);
    chk("step_count", count, 3);
    chk("step_done", done, 0);
    issue(C_CLEAR);
    m_count = 0;
    chk("idle_clear_count", count, 0);

    run_stop(5, 1'b0);
    chk("stop_count_5", count, 5);
    run_stop(2, 1'b0);
    chk("stop_count_7", count, 7);

    run_halt(6, 1'b1);
    done_cmds(1);

    step(1'b1);
    done_cmds(2);

    run_halt_reset(3);

`ifdef EXEC_BREAKPOINT_EN
    do_reset();
    bp_addr = 32'h10;
    bp_valid = 1'b1;
    expect_burst(5, 1'b0);
    issue(C_RUN);
    for (int t = 0; t < 30 && en; t++) tick();
    bp_valid = 1'b0;
    chk("bp_idle_ready", cmd_ready, 1);
    chk("bp_count", count, 5);
    run_halt(3, 1'b0);
    done_cmds(0);
`endif

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: step(1'b0);
        1: begin step(1'b1); done_cmds($urandom_range(0, 2)); end
        2: run_stop($urandom_range(1, 8), 1'b1);
        3: begin run_halt($urandom_range(1, 12), 1'b0); done_cmds($urandom_range(0, 2)); end
        4: begin run_halt($urandom_range(1, 12), 1'b1); done_cmds($urandom_range(0, 2)); end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            issue(C_STOP);
            chk("idle_stop_count", count, m_count);
            chk("idle_stop_enable", en, 0);
          end else begin
            issue(C_CLEAR);
            m_count = 0;
            chk("idle_clear_rand", count, 0);
          end
        end
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("bursts_drained", bq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
